memb_skew_buffer: RTL and testbench

- Skewing input buffer for the B (weight) operand of a DIM x DIM systolic matrix-multiply array.
- Accepts one row of B per enabled cycle, one element per column, on Bin.
- Each column passes through a shift register whose depth grows with the column index, so Bout presents B diagonally skewed: column c lags column 0 by c cycles.
- Sits between the host/MMIO write path and the top edge of the systolic array; companion to the A-side buffer.

---
 rtl/memb_skew_buffer.sv | 61 ++++++
 tb/tb_memb_skew_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memb_skew_buffer.sv
// memb_skew_buffer: diagonal skew buffer for the B (weight) operand of a
// DIM x DIM systolic array. Column c is a DIM+c deep shift register, so the
// rows written on Bin leave on Bout with column c lagging column 0 by c
// enabled cycles.
//
// Optional feature: define MEMB_OUT_REG_EN to add one free-running output
// register per column (clocked every cycle, independent of en). This delays
// Bout by one clock and relieves timing into the array top edge.
//
// DIM must be at least 2.
module memb_skew_buffer #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [BITS_AB-1:0]  Bin  [DIM-1:0],
    output logic signed [BITS_AB-1:0]  Bout [DIM-1:0]
);

    generate
        for (genvar c = 0; c < DIM; c++) begin : g_col
            localparam int DEPTH = DIM + c;

            logic signed [BITS_AB-1:0] stage [DEPTH];

            // Column shift register: advances one stage on enabled edges only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (en) begin
                    stage[0] <= Bin[c];
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

`ifdef MEMB_OUT_REG_EN
            logic signed [BITS_AB-1:0] out_q;

            // Retiming register after the final stage, clocked every cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= stage[DEPTH-1];
                end
            end

            assign Bout[c] = out_q;
`else
            assign Bout[c] = stage[DEPTH-1];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_memb_skew_buffer.sv
// Self-checking bench for memb_skew_buffer (DIM=8, BITS_AB=8, default build).
// Table-driven skew load/drain, hand-written hold / extremes / async reset
// sequences, and randomized matrices checked against a history-based model.
module tb_memb_skew_buffer;

    localparam int DIM     = 8;
    localparam int BITS_AB = 8;
    localparam int NDRAIN  = 3*DIM - 2;

    typedef logic [DIM-1:0][BITS_AB-1:0] prow_t;

    typedef struct {
        logic  en;
        prow_t bin;
        prow_t exp;
    } vec_t;

    logic                      clk;
    logic                      rst_n;
    logic                      en;
    logic signed [BITS_AB-1:0] Bin  [DIM-1:0];
    logic signed [BITS_AB-1:0] Bout [DIM-1:0];

    int    checks   = 0;
    int    failures = 0;
    prow_t hist [$];
    prow_t cur_mat [DIM];
    vec_t  vecs [DIM + NDRAIN];

    memb_skew_buffer #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .Bin  (Bin),
        .Bout (Bout)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout, required=finish)");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [BITS_AB-1:0] bval(input int r, input int c);
        int v;
        v = 8*r + c - 32;
        return v[BITS_AB-1:0];
    endfunction

    // Closed-form skew schedule: t counts enabled edges after the last load.
    function automatic prow_t formula(input int t);
        prow_t e;
        int k;
        for (int c = 0; c < DIM; c++) begin
            k = t - c;
            e[c] = (k >= 0 && k < DIM) ? cur_mat[k][c] : '0;
        end
        return e;
    endfunction

    // History model: a value entering on enabled edge n leaves after edge
    // n+DIM+c-1, so Bout[c] is the row written DIM+c-1 enabled edges ago.
    function automatic prow_t model_out();
        prow_t e;
        int idx;
        for (int c = 0; c < DIM; c++) begin
            idx = hist.size() - DIM - c;
            e[c] = (idx >= 0) ? hist[idx][c] : '0;
        end
        return e;
    endfunction

    task automatic step(input logic e, input prow_t row);
        en = e;
        for (int c = 0; c < DIM; c++) Bin[c] = row[c];
        @(posedge clk);
        #1;
        if (e) begin
            hist.push_back(row);
            if (hist.size() > 2*DIM) void'(hist.pop_front());
        end
    endtask

    task automatic checkOutput(input string name, input prow_t exp);
        for (int c = 0; c < DIM; c++) begin
            checks++;
            if (Bout[c] !== exp[c]) begin
                failures++;
                $display("[TB] FAIL %s col=%0d actual=%0d required=%0d",
                         name, c, Bout[c], $signed(exp[c]));
            end
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        en = 1'b0;
        #3 hist.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Load cur_mat, then drain, optionally pausing en or resetting mid-drain.
    task automatic applyStimulus(input string tag, input int hold_at, input int rst_at);
        prow_t snap;
        prow_t rnd;
        bit    cleared;
        cleared = 1'b0;
        do_reset();
        for (int r = 0; r < DIM; r++) begin
            step(1'b1, cur_mat[r]);
            checkOutput({tag, "_load"}, formula(r - (DIM-1)));
        end
        for (int t = 1; t <= NDRAIN; t++) begin
            if (t == hold_at) begin
                snap = formula(t - 1);
                for (int h = 0; h < 5; h++) begin
                    for (int c = 0; c < DIM; c++) rnd[c] = BITS_AB'($urandom);
                    step(1'b0, rnd);
                    checkOutput({tag, "_hold"}, snap);
                end
            end
            step(1'b1, '0);
            checkOutput({tag, "_drain"}, cleared ? prow_t'('0) : formula(t));
            if (t == rst_at) begin
                #3 rst_n = 1'b0;
                #1 checkOutput({tag, "_rst_async"}, '0);
                #2 rst_n = 1'b1;
                hist.delete();
                cleared = 1'b1;
            end
        end
    endtask

    initial begin
        int loaded;
        int drained;
        int budget;
        logic e;
        prow_t row;

        rst_n = 1'b0;
        en    = 1'b0;
        for (int c = 0; c < DIM; c++) Bin[c] = '0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_initial", '0);

        // Skew table: rows B[r][c] = 8r+c-32 then zero drain.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) cur_mat[r][c] = bval(r, c);
        for (int s = 0; s < DIM + NDRAIN; s++) begin
            vecs[s].en  = 1'b1;
            vecs[s].bin = (s < DIM) ? cur_mat[s] : '0;
            for (int c = 0; c < DIM; c++) begin
                int k;
                k = s - (DIM-1) - c;
                vecs[s].exp[c] = (k >= 0 && k < DIM) ? bval(k, c) : '0;
            end
        end
        for (int s = 0; s < DIM + NDRAIN; s++) begin
            step(vecs[s].en, vecs[s].bin);
            checkOutput($sformatf("skew_s%0d", s), vecs[s].exp);
        end

        // Reset after nonzero rows have been written.
        for (int r = 0; r < 2*DIM; r++) step(1'b1, cur_mat[r % DIM]);
        checkOutput("pre_reset_model", model_out());
        do_reset();
        checkOutput("reset_after_data", '0);

        // Enable hold mid-drain.
        applyStimulus("hold", 6, 0);

        // Signed extremes.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                cur_mat[r][c] = ((r + c) % 2 != 0) ? 8'h80 : 8'h7F;
        applyStimulus("extreme", 0, 0);

        // Asynchronous reset at drain cycle 10.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) cur_mat[r][c] = bval(r, c);
        applyStimulus("midrst", 0, 10);

        // Ten random matrices with random en gaps, checked against the model.
        for (int m = 0; m < 10; m++) begin
            do_reset();
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) cur_mat[r][c] = BITS_AB'($urandom);
            loaded  = 0;
            drained = 0;
            budget  = 0;
            while (drained < NDRAIN && budget < 200) begin
                e = ($urandom_range(4) != 0);
                if (e) row = (loaded < DIM) ? cur_mat[loaded] : '0;
                else for (int c = 0; c < DIM; c++) row[c] = BITS_AB'($urandom);
                step(e, row);
                if (e) begin
                    if (loaded < DIM) loaded++;
                    else drained++;
                end
                checkOutput($sformatf("rand_m%0d", m), model_out());
                budget++;
            end
            checks++;
            if (drained != NDRAIN) begin
                failures++;
                $display("[TB] FAIL rand_budget m=%0d actual=%0d required=%0d", m, drained, NDRAIN);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
